// File: rtl/state_sequencer.sv
// Multi-cycle control-unit sequencer: IF/ID/EXE/MEM/WB walk by opcode class,
// with memory wait states, halt/timeout handling and debug counters.
module state_sequencer #(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic [2:0]       State,
  output logic             instr_done,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_WB   = 3'b011,
    S_MEM  = 3'b100,
    S_HALT = 3'b111
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout;
  logic          is_jmp, is_jal, is_halt, is_br;
  logic          is_sw, is_lw, is_alu;
  logic          retire;

  assign State = state_q;

  // Opcode class decode
  always_comb begin
    is_jmp  = (Opcode == 6'b111000) || (Opcode == 6'b111001);
    is_jal  = (Opcode == 6'b111010);
    is_halt = (Opcode == 6'b111111);
    is_br   = (Opcode == 6'b110100) || (Opcode == 6'b110101) ||
              (Opcode == 6'b110110);
    is_sw   = (Opcode == 6'b110000);
    is_lw   = (Opcode == 6'b110001);
    is_alu  = (Opcode == 6'b000000) || (Opcode == 6'b000001) ||
              (Opcode == 6'b000010) || (Opcode == 6'b010000) ||
              (Opcode == 6'b010001) || (Opcode == 6'b010010) ||
              (Opcode == 6'b011000) || (Opcode == 6'b100110) ||
              (Opcode == 6'b100111);
  end

  // Next-state, wait counter and timeout detection
  always_comb begin
    state_d = S_IF;
    wait_d  = wait_q;
    timeout = 1'b0;
    unique case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_jal)
          state_d = S_WB;
        else if (is_halt)
          state_d = S_HALT;
        else if (is_br || is_sw || is_lw || is_alu)
          state_d = S_EXE;
        else
          state_d = S_IF;
      end
      S_EXE: begin
        if (is_sw || is_lw)
          state_d = S_MEM;
        else if (is_alu)
          state_d = S_WB;
        else
          state_d = S_IF;
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_IF;
        end else if ((MEM_WAIT_MAX != 0) &&
                     (wait_q == WW'(MEM_WAIT_MAX))) begin
          state_d = S_HALT;
          timeout = 1'b1;
        end else begin
          state_d = S_MEM;
          wait_d  = wait_q + 1'b1;
        end
      end
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    if (state_d == S_MEM && state_q != S_MEM)
      wait_d = '0;
  end

  assign retire = (state_q != S_IF) && (state_d == S_IF);

  // State register, status flags and counters
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IF;
      wait_q      <= '0;
      instr_done  <= 1'b0;
      halted      <= 1'b0;
      mem_err     <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      instr_done <= retire;
      halted     <= (state_d == S_HALT);
      if (timeout)
        mem_err <= 1'b1;
      if (retire)
        instr_count <= instr_count + 1'b1;
      if (state_q != S_HALT)
        cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: opcode walks, memory waits,
// timeout, halt and asynchronous reset.
module tb_state_sequencer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [5:0]  Opcode = 6'b000000;
  logic        mem_ready = 1'b0;
  logic [2:0]  State;
  logic        instr_done, halted, mem_err;
  logic [31:0] cycle_count, instr_count;

  int total = 0;
  int bad = 0;

  localparam logic [2:0] IF = 3'b000, ID = 3'b001, EX = 3'b010,
                         WB = 3'b011, MEM = 3'b100, HLT = 3'b111;

  state_sequencer #(.CNT_W(32), .MEM_WAIT_MAX(15)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .State(State), .instr_done(instr_done), .halted(halted),
    .mem_err(mem_err), .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag, input logic [2:0] exp);
    @(posedge CLK);
    #1;
    chk(tag, 32'(State), 32'(exp));
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    #1;
    chk("rst_state", 32'(State), 32'(IF));
    chk("rst_cyc", cycle_count, 32'd0);
    chk("rst_ins", instr_count, 32'd0);
    chk("rst_flags", {29'd0, instr_done, halted, mem_err}, 32'd0);
    #1 Reset = 1'b0;
  endtask

  task automatic mem_hold(input string tag, input int k);
    for (int i = 0; i < k; i++)
      tick(tag, MEM);
  endtask

  initial begin
    // 1: add
    #3 do_reset();
    Opcode = 6'b000000;
    tick("add_id", ID);
    tick("add_ex", EX);
    tick("add_wb", WB);
    chk("add_nodone", 32'(instr_done), 32'd0);
    tick("add_if", IF);
    chk("add_done", 32'(instr_done), 32'd1);
    chk("add_ins", instr_count, 32'd1);
    chk("add_cyc", cycle_count, 32'd4);
    Opcode = 6'b011000;
    tick("sll_id", ID);
    chk("done_pulse", 32'(instr_done), 32'd0);

    // 2: lw with three wait cycles
    do_reset();
    Opcode = 6'b110001;
    mem_ready = 1'b0;
    tick("lw_id", ID);
    tick("lw_ex", EX);
    mem_hold("lw_mem", 4);
    mem_ready = 1'b1;
    tick("lw_wb", WB);
    mem_ready = 1'b0;
    tick("lw_if", IF);
    chk("lw_cyc", cycle_count, 32'd8);
    chk("lw_ins", instr_count, 32'd1);
    chk("lw_done", 32'(instr_done), 32'd1);

    // 3: beq then j
    do_reset();
    Opcode = 6'b110100;
    tick("beq_id", ID);
    tick("beq_ex", EX);
    Opcode = 6'b111000;
    tick("beq_if", IF);
    tick("j_id", ID);
    tick("j_if", IF);
    chk("bj_ins", instr_count, 32'd2);
    chk("bj_cyc", cycle_count, 32'd5);

    // jal and unknown opcode (NOP)
    Opcode = 6'b111010;
    tick("jal_id", ID);
    tick("jal_wb", WB);
    Opcode = 6'b101010;
    tick("jal_if", IF);
    tick("nop_id", ID);
    tick("nop_if", IF);
    chk("jn_ins", instr_count, 32'd4);

    // 4: halt
    do_reset();
    Opcode = 6'b111111;
    tick("h_id", ID);
    tick("h_halt", HLT);
    chk("h_halted", 32'(halted), 32'd1);
    Opcode = 6'b000000;
    tick("h_stay1", HLT);
    tick("h_stay2", HLT);
    chk("h_cyc", cycle_count, 32'd2);
    chk("h_ins", instr_count, 32'd0);
    chk("h_done", 32'(instr_done), 32'd0);

    // 5: sw with memory never ready -> timeout
    do_reset();
    Opcode = 6'b110000;
    mem_ready = 1'b0;
    tick("to_id", ID);
    tick("to_ex", EX);
    mem_hold("to_mem", 16);
    chk("to_noerr", 32'(mem_err), 32'd0);
    tick("to_halt", HLT);
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_cyc", cycle_count, 32'd19);
    tick("to_stay", HLT);
    chk("to_sticky", 32'(mem_err), 32'd1);

    // boundary: ready on the 16th sMEM cycle, twice (wait ctr clears)
    do_reset();
    Opcode = 6'b110000;
    tick("b1_id", ID);
    tick("b1_ex", EX);
    mem_hold("b1_mem", 16);
    mem_ready = 1'b1;
    tick("b1_if", IF);
    mem_ready = 1'b0;
    tick("b2_id", ID);
    tick("b2_ex", EX);
    mem_hold("b2_mem", 16);
    mem_ready = 1'b1;
    tick("b2_if", IF);
    mem_ready = 1'b0;
    chk("b_err", 32'(mem_err), 32'd0);
    chk("b_ins", instr_count, 32'd2);
    chk("b_cyc", cycle_count, 32'd38);

    // 6: async reset mid-sMEM
    do_reset();
    Opcode = 6'b110001;
    tick("ar_id", ID);
    tick("ar_ex", EX);
    mem_hold("ar_mem", 2);
    #3 Reset = 1'b1;
    #1;
    chk("ar_state", 32'(State), 32'(IF));
    chk("ar_cyc", cycle_count, 32'd0);
    chk("ar_ins", instr_count, 32'd0);
    #1 Reset = 1'b0;
    Opcode = 6'b000111;
    tick("ar_id2", ID);
    tick("ar_if", IF);
    chk("ar_ins2", instr_count, 32'd1);
    chk("ar_done", 32'(instr_done), 32'd1);
    chk("ar_cyc2", cycle_count, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
